// File: rtl/tlb_lookup_arbiter.sv
// Arbitrates the shared TLB lookup ports between the rd and wr tlb_fsm instances:
// round-robin ownership, watchdog forced release and a one-cycle drain gap between owners.
module tlb_lookup_arbiter #(
    parameter int unsigned HOLD_MAX_CYCLES = 1024,
    parameter int unsigned CNT_BITS        = 16,
    parameter int unsigned STAT_BITS       = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 rd_lock,
    input  logic                 rd_unlock,
    input  logic                 wr_lock,
    input  logic                 wr_unlock,
    output logic [1:0]           mutex,
    output logic                 rd_grant,
    output logic                 wr_grant,
    output logic                 timeout_irq,
    output logic                 timeout_owner,
    output logic [STAT_BITS-1:0] stat_rd_grants,
    output logic [STAT_BITS-1:0] stat_wr_grants,
    output logic [STAT_BITS-1:0] stat_timeouts
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RD_OWN = 2'd1,
        S_WR_OWN = 2'd2,
        S_DRAIN  = 2'd3
    } state_e;

    localparam bit                  WDOG_EN    = (HOLD_MAX_CYCLES != 0);
    localparam logic [CNT_BITS-1:0] HOLD_LAST  =
        CNT_BITS'((HOLD_MAX_CYCLES == 0) ? 0 : HOLD_MAX_CYCLES - 1);
    localparam logic [1:0]          MUTEX_FREE = 2'b01;
    localparam logic [1:0]          MUTEX_RD   = 2'b00;
    localparam logic [1:0]          MUTEX_WR   = 2'b10;

    state_e                 state_q, state_d;
    logic [CNT_BITS-1:0]    hold_cnt_q, hold_cnt_d;
    logic                   last_wr_q, last_wr_d;
    logic [1:0]             mutex_q, mutex_d;
    logic                   rd_grant_q, rd_grant_d;
    logic                   wr_grant_q, wr_grant_d;
    logic                   timeout_irq_q, timeout_irq_d;
    logic                   timeout_owner_q, timeout_owner_d;
    logic [STAT_BITS-1:0]   stat_rd_q, stat_rd_d;
    logic [STAT_BITS-1:0]   stat_wr_q, stat_wr_d;
    logic [STAT_BITS-1:0]   stat_to_q, stat_to_d;
    logic                   owner_unlock;

    function automatic logic [STAT_BITS-1:0] sat_inc(input logic [STAT_BITS-1:0] v);
        return (v == '1) ? v : v + STAT_BITS'(1);
    endfunction

    // Next-state, hold counter, statistics and registered output decode
    always_comb begin
        state_d         = state_q;
        hold_cnt_d      = hold_cnt_q;
        last_wr_d       = last_wr_q;
        timeout_irq_d   = 1'b0;
        timeout_owner_d = timeout_owner_q;
        stat_rd_d       = stat_rd_q;
        stat_wr_d       = stat_wr_q;
        stat_to_d       = stat_to_q;
        owner_unlock    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rd_lock && (!wr_lock || last_wr_q)) begin
                    state_d    = S_RD_OWN;
                    last_wr_d  = 1'b0;
                    hold_cnt_d = '0;
                    stat_rd_d  = sat_inc(stat_rd_q);
                end else if (wr_lock) begin
                    state_d    = S_WR_OWN;
                    last_wr_d  = 1'b1;
                    hold_cnt_d = '0;
                    stat_wr_d  = sat_inc(stat_wr_q);
                end
            end
            S_RD_OWN, S_WR_OWN: begin
                owner_unlock = (state_q == S_RD_OWN) ? rd_unlock : wr_unlock;
                if (owner_unlock) begin
                    state_d = S_DRAIN;
                end else if (WDOG_EN && (hold_cnt_q == HOLD_LAST)) begin
                    state_d         = S_DRAIN;
                    timeout_irq_d   = 1'b1;
                    timeout_owner_d = (state_q == S_WR_OWN);
                    stat_to_d       = sat_inc(stat_to_q);
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + CNT_BITS'(1);
                end
            end
            S_DRAIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        mutex_d    = (state_d == S_RD_OWN) ? MUTEX_RD :
                     (state_d == S_WR_OWN) ? MUTEX_WR : MUTEX_FREE;
        rd_grant_d = (state_d == S_RD_OWN);
        wr_grant_d = (state_d == S_WR_OWN);
    end

    // last_wr resets to 1 so rd wins the first tie after reset
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q         <= S_IDLE;
            hold_cnt_q      <= '0;
            last_wr_q       <= 1'b1;
            mutex_q         <= MUTEX_FREE;
            rd_grant_q      <= 1'b0;
            wr_grant_q      <= 1'b0;
            timeout_irq_q   <= 1'b0;
            timeout_owner_q <= 1'b0;
            stat_rd_q       <= '0;
            stat_wr_q       <= '0;
            stat_to_q       <= '0;
        end else begin
            state_q         <= state_d;
            hold_cnt_q      <= hold_cnt_d;
            last_wr_q       <= last_wr_d;
            mutex_q         <= mutex_d;
            rd_grant_q      <= rd_grant_d;
            wr_grant_q      <= wr_grant_d;
            timeout_irq_q   <= timeout_irq_d;
            timeout_owner_q <= timeout_owner_d;
            stat_rd_q       <= stat_rd_d;
            stat_wr_q       <= stat_wr_d;
            stat_to_q       <= stat_to_d;
        end
    end

    assign mutex          = mutex_q;
    assign rd_grant       = rd_grant_q;
    assign wr_grant       = wr_grant_q;
    assign timeout_irq    = timeout_irq_q;
    assign timeout_owner  = timeout_owner_q;
    assign stat_rd_grants = stat_rd_q;
    assign stat_wr_grants = stat_wr_q;
    assign stat_timeouts  = stat_to_q;

endmodule

// File: tb/tb_tlb_lookup_arbiter.sv
// Bench for tlb_lookup_arbiter: directed scenarios plus randomized traffic against an
// ownership-level reference model (owner, cycles held, saturating tallies).
module tb_tlb_lookup_arbiter;

    localparam int unsigned HOLD      = 8;
    localparam int unsigned STAT_BITS = 4;
    localparam int          STAT_MAX  = (1 << STAT_BITS) - 1;

    logic                 aclk = 1'b0;
    logic                 aresetn = 1'b0;
    logic                 rd_lock = 1'b0;
    logic                 rd_unlock = 1'b0;
    logic                 wr_lock = 1'b0;
    logic                 wr_unlock = 1'b0;
    logic [1:0]           mutex;
    logic                 rd_grant;
    logic                 wr_grant;
    logic                 timeout_irq;
    logic                 timeout_owner;
    logic [STAT_BITS-1:0] stat_rd_grants;
    logic [STAT_BITS-1:0] stat_wr_grants;
    logic [STAT_BITS-1:0] stat_timeouts;

    int checks = 0;
    int errors = 0;

    // Reference model: owner 0 none, 1 rd, 2 wr
    int m_owner;
    bit m_drain;
    int m_held;
    bit m_last_wr;
    bit m_irq;
    bit m_towner;
    int m_srd, m_swr, m_sto;

    tlb_lookup_arbiter #(
        .HOLD_MAX_CYCLES(HOLD),
        .CNT_BITS       (16),
        .STAT_BITS      (STAT_BITS)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .rd_lock       (rd_lock),
        .rd_unlock     (rd_unlock),
        .wr_lock       (wr_lock),
        .wr_unlock     (wr_unlock),
        .mutex         (mutex),
        .rd_grant      (rd_grant),
        .wr_grant      (wr_grant),
        .timeout_irq   (timeout_irq),
        .timeout_owner (timeout_owner),
        .stat_rd_grants(stat_rd_grants),
        .stat_wr_grants(stat_wr_grants),
        .stat_timeouts (stat_timeouts)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (aresetn) begin
            assert (!(rd_grant && wr_grant))
                else $error("FAIL grant_excl: rd_grant=%0b wr_grant=%0b, required not both 1", rd_grant, wr_grant);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic int sat(input int v);
        return (v >= STAT_MAX) ? STAT_MAX : v + 1;
    endfunction

    function automatic logic [1:0] exp_mutex();
        return (m_owner == 1) ? 2'b00 : (m_owner == 2) ? 2'b10 : 2'b01;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_drain = 0; m_held = 0; m_last_wr = 1;
        m_irq = 0; m_towner = 0; m_srd = 0; m_swr = 0; m_sto = 0;
    endtask

    task automatic model_step();
        bit rel;
        m_irq = 0;
        if (m_drain) begin
            m_drain = 0;
        end else if (m_owner == 0) begin
            if (rd_lock && wr_lock) begin
                m_owner = m_last_wr ? 1 : 2;
            end else if (rd_lock) begin
                m_owner = 1;
            end else if (wr_lock) begin
                m_owner = 2;
            end
            if (m_owner != 0) begin
                m_held    = 0;
                m_last_wr = (m_owner == 2);
                if (m_owner == 1) m_srd = sat(m_srd);
                else m_swr = sat(m_swr);
            end
        end else begin
            m_held++;
            rel = (m_owner == 1) ? rd_unlock : wr_unlock;
            if (rel) begin
                m_owner = 0; m_drain = 1;
            end else if (m_held == HOLD) begin
                m_towner = (m_owner == 2);
                m_irq = 1; m_sto = sat(m_sto);
                m_owner = 0; m_drain = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        rd_lock = 0; rd_unlock = 0; wr_lock = 0; wr_unlock = 0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({mutex, rd_grant, wr_grant, timeout_irq, timeout_owner} !== 6'b010000) begin
            errors++;
            $display("FAIL reset_outputs: got mutex=%b rd=%b wr=%b irq=%b towner=%b, required 01 0 0 0 0",
                     mutex, rd_grant, wr_grant, timeout_irq, timeout_owner);
        end
        checks++;
        if ({stat_rd_grants, stat_wr_grants, stat_timeouts} !== '0) begin
            errors++;
            $display("FAIL reset_stats: got %0d %0d %0d, required 0 0 0",
                     stat_rd_grants, stat_wr_grants, stat_timeouts);
        end
    endtask

    task automatic test_single_rd();
        repeat (3) tick();
        rd_lock = 1;
        tick();
        rd_lock = 0;
        checks++;
        if (mutex !== 2'b00 || rd_grant !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got mutex=%b rd_grant=%b, required 00 1", mutex, rd_grant);
        end
        repeat (3) tick();
        rd_unlock = 1;
        tick();
        rd_unlock = 0;
        checks++;
        if (mutex !== 2'b01 || rd_grant !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got mutex=%b rd_grant=%b, required 01 0", mutex, rd_grant);
        end
        tick();
        checks++;
        if (mutex !== 2'b01 || stat_rd_grants !== 4'd1 || stat_wr_grants !== 4'd0) begin
            errors++;
            $display("FAIL single_idle: got mutex=%b stat_rd=%0d stat_wr=%0d, required 01 1 0",
                     mutex, stat_rd_grants, stat_wr_grants);
        end
    endtask

    task automatic test_reset_mid_own();
        rd_lock = 1;
        tick();
        rd_lock = 0;
        tick();
        aresetn = 1'b0;
        #1;
        checks++;
        if (mutex !== 2'b01 || rd_grant !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_own: got mutex=%b rd_grant=%b, required 01 0", mutex, rd_grant);
        end
        @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        model_reset();
        checks++;
        if ({stat_rd_grants, stat_wr_grants, stat_timeouts} !== '0) begin
            errors++;
            $display("FAIL reset_mid_stats: got %0d %0d %0d, required 0 0 0",
                     stat_rd_grants, stat_wr_grants, stat_timeouts);
        end
    endtask

    task automatic test_tie();
        int n;
        bit who;
        rd_lock = 1;
        wr_lock = 1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!(rd_grant || wr_grant) && n < 10) begin
                tick();
                n++;
            end
            checks++;
            if (n >= 10) begin
                errors++;
                $display("FAIL tie_wait: grant %0d not seen within 10 cycles", g);
                break;
            end
            who = wr_grant;
            checks++;
            if (who !== g[0] || n != ((g == 0) ? 1 : 2)) begin
                errors++;
                $display("FAIL tie_order: grant %0d went to %s after %0d cycles, required %s after %0d",
                         g, who ? "wr" : "rd", n, g[0] ? "wr" : "rd", (g == 0) ? 1 : 2);
            end
            repeat (3) tick();
            if (who) wr_unlock = 1; else rd_unlock = 1;
            tick();
            rd_unlock = 0;
            wr_unlock = 0;
        end
        rd_lock = 0;
        wr_lock = 0;
        repeat (2) tick();
        checks++;
        if (stat_rd_grants !== 4'd2 || stat_wr_grants !== 4'd2) begin
            errors++;
            $display("FAIL tie_stats: got rd=%0d wr=%0d, required 2 2", stat_rd_grants, stat_wr_grants);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        wr_lock = 1;
        tick();
        wr_lock = 0;
        checks++;
        if (mutex !== 2'b10 || wr_grant !== 1'b1) begin
            errors++;
            $display("FAIL wdog_grant: got mutex=%b wr_grant=%b, required 10 1", mutex, wr_grant);
        end
        repeat (7) tick();
        checks++;
        if (mutex !== 2'b10 || timeout_irq !== 1'b0) begin
            errors++;
            $display("FAIL wdog_hold: got mutex=%b irq=%b after 7 cycles, required 10 0", mutex, timeout_irq);
        end
        tick();
        checks++;
        if (mutex !== 2'b01 || timeout_irq !== 1'b1 || timeout_owner !== 1'b1 || stat_timeouts !== 4'd1) begin
            errors++;
            $display("FAIL wdog_fire: got mutex=%b irq=%b towner=%b sto=%0d, required 01 1 1 1",
                     mutex, timeout_irq, timeout_owner, stat_timeouts);
        end
        tick();
        checks++;
        if (timeout_irq !== 1'b0 || timeout_owner !== 1'b1) begin
            errors++;
            $display("FAIL wdog_pulse: got irq=%b towner=%b, required 0 1", timeout_irq, timeout_owner);
        end
    endtask

    task automatic test_unlock_last();
        rd_lock = 1;
        tick();
        rd_lock = 0;
        repeat (7) tick();
        checks++;
        if (rd_grant !== 1'b1) begin
            errors++;
            $display("FAIL last_hold: got rd_grant=%b after 7 cycles, required 1", rd_grant);
        end
        rd_unlock = 1;
        tick();
        rd_unlock = 0;
        checks++;
        if (mutex !== 2'b01 || timeout_irq !== 1'b0 || stat_timeouts !== 4'd1 || timeout_owner !== 1'b1) begin
            errors++;
            $display("FAIL last_unlock: got mutex=%b irq=%b sto=%0d towner=%b, required 01 0 1 1",
                     mutex, timeout_irq, stat_timeouts, timeout_owner);
        end
        tick();
    endtask

    task automatic test_nonowner_unlock();
        rd_lock = 1;
        tick();
        rd_lock = 0;
        wr_lock = 1;
        wr_unlock = 1;
        tick();
        wr_unlock = 0;
        checks++;
        if (mutex !== 2'b00 || rd_grant !== 1'b1 || wr_grant !== 1'b0) begin
            errors++;
            $display("FAIL nonowner_unlock: got mutex=%b rd=%b wr=%b, required 00 1 0", mutex, rd_grant, wr_grant);
        end
        rd_unlock = 1;
        tick();
        rd_unlock = 0;
        tick();
        tick();
        checks++;
        if (mutex !== 2'b10 || wr_grant !== 1'b1) begin
            errors++;
            $display("FAIL pending_wr: got mutex=%b wr_grant=%b, required 10 1", mutex, wr_grant);
        end
        wr_lock = 0;
        wr_unlock = 1;
        tick();
        wr_unlock = 0;
        repeat (2) tick();
    endtask

    task automatic test_random();
        logic [19:0] got, exp;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rd_lock   = ($urandom_range(0, 3) != 0);
            wr_lock   = ($urandom_range(0, 3) != 0);
            rd_unlock = ($urandom_range(0, 5) == 0);
            wr_unlock = ($urandom_range(0, 5) == 0);
            tick();
            got = {mutex, rd_grant, wr_grant, timeout_irq, timeout_owner,
                   stat_rd_grants, stat_wr_grants, stat_timeouts};
            exp = {exp_mutex(), m_owner == 1, m_owner == 2, m_irq, m_towner,
                   STAT_BITS'(m_srd), STAT_BITS'(m_swr), STAT_BITS'(m_sto)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_cycle %0d: got %b, required %b", c, got, exp);
            end
        end
        rd_lock = 0; wr_lock = 0; rd_unlock = 0; wr_unlock = 0;
        checks++;
        if (stat_rd_grants !== 4'(STAT_MAX) || stat_wr_grants !== 4'(STAT_MAX)) begin
            errors++;
            $display("FAIL random_saturate: got rd=%0d wr=%0d, required %0d %0d",
                     stat_rd_grants, stat_wr_grants, STAT_MAX, STAT_MAX);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_rd();
        test_reset_mid_own();
        test_tie();
        test_watchdog();
        test_unlock_last();
        test_nonowner_unlock();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
